maxpool_l1: RTL and testbench

- 2x2 stride-2 max-pooling stage directly downstream of the first convolution layer.
- Reads the two 26x26 signed 18-bit feature maps held in the conv layer's channel RAMs.
- Writes two 13x13 pooled maps, row-major, into the layer-1 channel RAMs.
- Both channels are processed in lockstep through one shared read address. Starts on a pulse from the core sequencer and reports completion with a one-cycle done pulse.

---
 rtl/cnn_pkg.sv | 23 ++
 rtl/pool_max_unit.sv | 42 ++++
 rtl/maxpool_l1.sv | 221 ++++++++++++++++++++++
 tb/tb_maxpool_l1.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cnn_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : cnn_pkg
//  Brief    : Shared CNN constants, data type and pooling FSM state encoding.
//  Revision : 1.0 - initial release
// ============================================================================
package cnn_pkg;

    localparam int DW     = 18;
    localparam int L0_DIM = 26;
    localparam int L1_DIM = 13;

    typedef logic signed [DW-1:0] data_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RD   = 2'd1,
        WR   = 2'd2,
        DONE = 2'd3
    } state_t;

endpackage
`default_nettype wire

// File: rtl/pool_max_unit.sv
`default_nettype none
// ============================================================================
//  Module   : pool_max_unit
//  Brief    : Per-channel running signed maximum with init/update enables.
//  Revision : 1.0 - initial release
// ============================================================================
module pool_max_unit
    import cnn_pkg::*;
(
    input  logic  clk,
    input  logic  rst,
    input  logic  i_init,
    input  logic  i_update,
    input  data_t i_din,
    output data_t o_max_next
);

    data_t r_max;
    data_t w_max_next;

    // Next value is exposed so the final sample can be folded in on the write edge.
    always_comb begin
        w_max_next = r_max;
        if (i_init) begin
            w_max_next = i_din;
        end else if (i_update && (i_din > r_max)) begin
            w_max_next = i_din;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_max <= '0;
        end else if (i_init || i_update) begin
            r_max <= w_max_next;
        end
    end

    assign o_max_next = w_max_next;

endmodule
`default_nettype wire

// File: rtl/maxpool_l1.sv
`default_nettype none
// ============================================================================
//  Module   : maxpool_l1
//  Brief    : 2x2 stride-2 max-pool of two conv-layer maps into layer-1 RAMs.
//  Revision : 1.0 - initial release
// ============================================================================
module maxpool_l1
    import cnn_pkg::*;
#(
    parameter int IN_DIM = L0_DIM,
    parameter int DW     = 18
)(
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        start,
    output logic                                        busy,
    output logic                                        done,
    output logic [$clog2(IN_DIM*IN_DIM)-1:0]            rd_addr,
    input  logic [DW-1:0]                               rd_data0,
    input  logic [DW-1:0]                               rd_data1,
    output logic                                        wr_en,
    output logic [$clog2((IN_DIM/2)*(IN_DIM/2))-1:0]    wr_addr,
    output logic [DW-1:0]                               wr_data0,
    output logic [DW-1:0]                               wr_data1
);

    localparam int OUT_DIM = IN_DIM / 2;
    localparam int c_aw    = $clog2(IN_DIM * IN_DIM);
    localparam int c_ow    = $clog2(OUT_DIM * OUT_DIM);
    localparam int c_cw    = $clog2(OUT_DIM);

    localparam logic [c_aw-1:0] c_off_1    = c_aw'(1);
    localparam logic [c_aw-1:0] c_off_row  = c_aw'(IN_DIM);
    localparam logic [c_aw-1:0] c_off_diag = c_aw'(IN_DIM + 1);
    localparam logic [c_aw-1:0] c_step_col = c_aw'(2);
    localparam logic [c_aw-1:0] c_step_row = c_aw'(IN_DIM + 2);
    localparam logic [c_cw-1:0] c_cnt_one  = c_cw'(1);
    localparam logic [c_cw-1:0] c_cnt_last = c_cw'(OUT_DIM - 1);
    localparam logic [c_ow-1:0] c_pix_one  = c_ow'(1);

    localparam logic [2:0] c_p0 = 3'd0;
    localparam logic [2:0] c_p1 = 3'd1;
    localparam logic [2:0] c_p2 = 3'd2;
    localparam logic [2:0] c_p3 = 3'd3;
    localparam logic [2:0] c_p4 = 3'd4;

    if ((IN_DIM % 2) != 0) begin : g_odd_dim
        $error("maxpool_l1: IN_DIM must be even");
    end

    state_t           r_state,    w_state_n;
    logic [2:0]       r_phase,    w_phase_n;
    logic [c_aw-1:0]  r_base,     w_base_n;
    logic [c_cw-1:0]  r_col,      w_col_n;
    logic [c_cw-1:0]  r_row,      w_row_n;
    logic [c_ow-1:0]  r_pix,      w_pix_n;
    logic [c_aw-1:0]  r_rd_addr,  w_rd_addr_n;
    logic             r_busy,     w_busy_n;
    logic             r_done,     w_done_n;
    logic             r_wr_en,    w_wr_en_n;
    logic [c_ow-1:0]  r_wr_addr,  w_wr_addr_n;
    logic [DW-1:0]    r_wr_data0, w_wr_data0_n;
    logic [DW-1:0]    r_wr_data1, w_wr_data1_n;

    logic  w_init;
    logic  w_upd;
    logic  w_last_col;
    logic  w_last_pix;
    data_t w_max0;
    data_t w_max1;

    pool_max_unit u_max0 (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_init),
        .i_update   (w_upd),
        .i_din      (rd_data0),
        .o_max_next (w_max0)
    );

    pool_max_unit u_max1 (
        .clk        (clk),
        .rst        (rst),
        .i_init     (w_init),
        .i_update   (w_upd),
        .i_din      (rd_data1),
        .o_max_next (w_max1)
    );

    assign w_last_col = (r_col == c_cnt_last);
    assign w_last_pix = w_last_col && (r_row == c_cnt_last);

    // Address issued on the edge entering a phase; its data is sampled one phase later.
    always_comb begin
        w_state_n    = r_state;
        w_phase_n    = r_phase;
        w_base_n     = r_base;
        w_col_n      = r_col;
        w_row_n      = r_row;
        w_pix_n      = r_pix;
        w_rd_addr_n  = r_rd_addr;
        w_busy_n     = r_busy;
        w_done_n     = 1'b0;
        w_wr_en_n    = 1'b0;
        w_wr_addr_n  = '0;
        w_wr_data0_n = '0;
        w_wr_data1_n = '0;
        w_init       = 1'b0;
        w_upd        = 1'b0;

        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_n   = RD;
                    w_phase_n   = c_p0;
                    w_rd_addr_n = r_base;
                    w_busy_n    = 1'b1;
                end
            end
            RD: begin
                case (r_phase)
                    c_p0: begin
                        w_rd_addr_n = r_base + c_off_1;
                        w_phase_n   = c_p1;
                    end
                    c_p1: begin
                        w_init      = 1'b1;
                        w_rd_addr_n = r_base + c_off_row;
                        w_phase_n   = c_p2;
                    end
                    c_p2: begin
                        w_upd       = 1'b1;
                        w_rd_addr_n = r_base + c_off_diag;
                        w_phase_n   = c_p3;
                    end
                    c_p3: begin
                        w_upd     = 1'b1;
                        w_phase_n = c_p4;
                    end
                    default: begin
                        w_upd        = 1'b1;
                        w_state_n    = WR;
                        w_wr_en_n    = 1'b1;
                        w_wr_addr_n  = r_pix;
                        w_wr_data0_n = w_max0;
                        w_wr_data1_n = w_max1;
                    end
                endcase
            end
            WR: begin
                if (w_last_pix) begin
                    w_state_n = DONE;
                    w_done_n  = 1'b1;
                    w_base_n  = '0;
                    w_col_n   = '0;
                    w_row_n   = '0;
                    w_pix_n   = '0;
                end else begin
                    w_state_n = RD;
                    w_phase_n = c_p0;
                    w_pix_n   = r_pix + c_pix_one;
                    if (w_last_col) begin
                        w_col_n  = '0;
                        w_row_n  = r_row + c_cnt_one;
                        w_base_n = r_base + c_step_row;
                    end else begin
                        w_col_n  = r_col + c_cnt_one;
                        w_base_n = r_base + c_step_col;
                    end
                    w_rd_addr_n = w_base_n;
                end
            end
            default: begin
                w_state_n = IDLE;
                w_busy_n  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= IDLE;
            r_phase    <= c_p0;
            r_base     <= '0;
            r_col      <= '0;
            r_row      <= '0;
            r_pix      <= '0;
            r_rd_addr  <= '0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_wr_en    <= 1'b0;
            r_wr_addr  <= '0;
            r_wr_data0 <= '0;
            r_wr_data1 <= '0;
        end else begin
            r_state    <= w_state_n;
            r_phase    <= w_phase_n;
            r_base     <= w_base_n;
            r_col      <= w_col_n;
            r_row      <= w_row_n;
            r_pix      <= w_pix_n;
            r_rd_addr  <= w_rd_addr_n;
            r_busy     <= w_busy_n;
            r_done     <= w_done_n;
            r_wr_en    <= w_wr_en_n;
            r_wr_addr  <= w_wr_addr_n;
            r_wr_data0 <= w_wr_data0_n;
            r_wr_data1 <= w_wr_data1_n;
        end
    end

    assign busy     = r_busy;
    assign done     = r_done;
    assign rd_addr  = r_rd_addr;
    assign wr_en    = r_wr_en;
    assign wr_addr  = r_wr_addr;
    assign wr_data0 = r_wr_data0;
    assign wr_data1 = r_wr_data1;

endmodule
`default_nettype wire

// File: tb/tb_maxpool_l1.sv
`default_nettype none
// ============================================================================
//  Module   : tb_maxpool_l1
//  Brief    : Directed self-checking bench for maxpool_l1.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_maxpool_l1;

    logic        clk;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [9:0]  rd_addr;
    logic [17:0] rd_data0;
    logic [17:0] rd_data1;
    logic        wr_en;
    logic [7:0]  wr_addr;
    logic [17:0] wr_data0;
    logic [17:0] wr_data1;

    logic [17:0] mem0 [0:675];
    logic [17:0] mem1 [0:675];
    logic [17:0] out0 [0:168];
    logic [17:0] out1 [0:168];

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    logic mon_clr;
    int   wr_cnt;
    int   next_exp;
    int   first_wr;
    int   done_cnt;
    int   done_cyc;
    bit   order_bad;
    bit   idle_bad;

    maxpool_l1 dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .busy     (busy),
        .done     (done),
        .rd_addr  (rd_addr),
        .rd_data0 (rd_data0),
        .rd_data1 (rd_data1),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data0 (wr_data0),
        .wr_data1 (wr_data1)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Upstream RAMs: one-cycle read latency.
    always @(posedge clk) begin
        rd_data0 <= mem0[rd_addr];
        rd_data1 <= mem1[rd_addr];
    end

    // Layer-1 RAM capture plus write-sequence bookkeeping.
    always @(posedge clk) begin
        if (mon_clr) begin
            wr_cnt    <= 0;
            next_exp  <= 0;
            first_wr  <= -1;
            done_cnt  <= 0;
            done_cyc  <= -1;
            order_bad <= 1'b0;
            idle_bad  <= 1'b0;
            for (int i = 0; i < 169; i++) begin
                out0[i] <= 18'h2AAAA;
                out1[i] <= 18'h2AAAA;
            end
        end else begin
            if (wr_en) begin
                if (wr_addr < 8'd169) begin
                    out0[wr_addr] <= wr_data0;
                    out1[wr_addr] <= wr_data1;
                end
                if (wr_cnt == 0) first_wr <= cyc;
                if (int'(wr_addr) != next_exp) order_bad <= 1'b1;
                next_exp <= next_exp + 1;
                wr_cnt   <= wr_cnt + 1;
            end else if (wr_addr != 8'd0 || wr_data0 != 18'd0 || wr_data1 != 18'd0) begin
                idle_bad <= 1'b1;
            end
            if (done) begin
                done_cnt <= done_cnt + 1;
                done_cyc <= cyc;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_ramp();
        for (int i = 0; i < 676; i++) begin
            mem0[i] = 18'(i);
            mem1[i] = 18'(675 - i);
        end
    endtask

    task automatic load_signed();
        for (int i = 0; i < 676; i++) begin
            mem0[i] = 18'h3FFFB;
            mem1[i] = 18'h3FFFB;
        end
        mem1[27] = 18'h00000;
        mem1[0]  = 18'h1FFFF;
    endtask

    // Called at a negedge; returns at the negedge of the cycle after done.
    task automatic run_pass(input bit extra);
        int e;
        bit got_done;
        mon_clr = 1'b1;
        start   = 1'b1;
        e       = cyc;
        @(negedge clk);
        mon_clr = 1'b0;
        start   = 1'b0;
        chk("busy_after_start", 32'(busy), 32'd1);
        got_done = 1'b0;
        for (int n = 0; n < 1200 && !got_done; n++) begin
            @(negedge clk);
            start = extra && (cyc == e + 10);
            if (done) begin
                got_done = 1'b1;
                chk("done_time", cyc, e + 1015);
                if (extra) start = 1'b1;
            end
        end
        chk("done_seen", 32'(got_done), 32'd1);
        @(negedge clk);
        start = 1'b0;
        chk("busy_after_done", 32'(busy), 32'd0);
        chk("done_width", 32'(done), 32'd0);
        chk("first_wr_time", first_wr, e + 6);
        chk("wr_count", wr_cnt, 169);
        chk("wr_order", 32'(order_bad), 32'd0);
        chk("idle_outputs_zero", 32'(idle_bad), 32'd0);
        chk("done_count", done_cnt, 1);
        chk("done_edge", done_cyc, e + 1015);
    endtask

    task automatic check_ramp(input string tag);
        for (int k = 0; k < 169; k++) begin
            int r;
            int c;
            r = k / 13;
            c = k % 13;
            chk($sformatf("%s_out0[%0d]", tag, k), 32'(out0[k]), 32'(18'((2*r+1)*26 + 2*c + 1)));
            chk($sformatf("%s_out1[%0d]", tag, k), 32'(out1[k]), 32'(18'(675 - (2*r*26 + 2*c))));
        end
    endtask

    task automatic check_signed();
        for (int k = 0; k < 169; k++) begin
            logic [17:0] exp1;
            exp1 = (k == 0) ? 18'h1FFFF : 18'h3FFFB;
            chk($sformatf("signed_out0[%0d]", k), 32'(out0[k]), 32'(18'h3FFFB));
            chk($sformatf("signed_out1[%0d]", k), 32'(out1[k]), 32'(exp1));
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int snap;
        rst     = 1'b1;
        start   = 1'b0;
        mon_clr = 1'b1;
        load_ramp();
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_rd_addr", 32'(rd_addr), 32'd0);
        chk("rst_wr_en", 32'(wr_en), 32'd0);
        chk("rst_wr_addr", 32'(wr_addr), 32'd0);
        chk("rst_wr_data0", 32'(wr_data0), 32'd0);
        chk("rst_wr_data1", 32'(wr_data1), 32'd0);
        rst = 1'b0;
        @(negedge clk);
        mon_clr = 1'b0;

        // Ramp pass with stray starts at E+10 and on the done cycle.
        run_pass(1'b1);
        check_ramp("ramp");

        // Back-to-back pass, started the cycle after done, with signed data.
        load_signed();
        run_pass(1'b0);
        check_signed();

        // Reset while pixel 50 is being read.
        load_ramp();
        mon_clr = 1'b1;
        start   = 1'b1;
        @(negedge clk);
        mon_clr = 1'b0;
        start   = 1'b0;
        for (int n = 0; n < 400 && wr_cnt < 50; n++) @(negedge clk);
        chk("reached_pixel50", wr_cnt, 50);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_done", 32'(done), 32'd0);
        chk("midrst_rd_addr", 32'(rd_addr), 32'd0);
        chk("midrst_wr_en", 32'(wr_en), 32'd0);
        chk("midrst_wr_addr", 32'(wr_addr), 32'd0);
        chk("midrst_wr_data", 32'({wr_data0[15:0], wr_data1[15:0]}), 32'd0);
        snap = wr_cnt;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("midrst_no_writes", wr_cnt, snap);
        chk("midrst_idle", 32'(busy), 32'd0);

        run_pass(1'b0);
        check_ramp("after_rst");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
